// File: rtl/fc_act_loader.sv
// fc_act_loader: collects a serial activation stream into the parallel vector x
// that feeds a combinational FC layer, holds x for SETTLE cycles, then samples
// the layer result z and offers it downstream on a valid/ready handshake.
module fc_act_loader #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned IN     = 128,
    parameter int unsigned SETTLE = 2,
    parameter int unsigned ZW     = WIDTH * 2 + $clog2(IN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_last,
    output logic [WIDTH-1:0] x [0:IN-1],
    input  logic [ZW-1:0]    z,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [ZW-1:0]    m_data,
    output logic             m_err
);

    localparam int unsigned CW = (IN > 1) ? $clog2(IN) : 1;
    localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(IN - 1);
    localparam logic [SW-1:0] SET_LAST = SW'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_OUT    = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   scnt_q, scnt_d;
    logic            err_q, err_d;
    logic            s_ready_d;
    logic            m_valid_d;
    logic            beat_c;
    logic            sample_c;
    logic            clear_c;
    logic            last_idx_c;

    // Next-state, counter and strobe decode; registered outputs follow next state
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        scnt_d     = scnt_q;
        err_d      = err_q;
        beat_c     = 1'b0;
        sample_c   = 1'b0;
        clear_c    = 1'b0;
        last_idx_c = (cnt_q == CNT_LAST);

        case (state_q)
            ST_FILL: begin
                if (s_valid && s_ready) begin
                    beat_c = 1'b1;
                    if (s_last || last_idx_c) begin
                        // Early last or missing last both flag the frame
                        if (s_last != last_idx_c) begin
                            err_d = 1'b1;
                        end
                        state_d = ST_SETTLE;
                        cnt_d   = '0;
                        scnt_d  = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ST_SETTLE: begin
                if (scnt_q == SET_LAST) begin
                    sample_c = 1'b1;
                    state_d  = ST_OUT;
                end else begin
                    scnt_d = scnt_q + SW'(1);
                end
            end
            ST_OUT: begin
                if (m_valid && m_ready) begin
                    clear_c = 1'b1;
                    err_d   = 1'b0;
                    state_d = ST_FILL;
                end
            end
            default: begin
                state_d = ST_FILL;
                cnt_d   = '0;
                scnt_d  = '0;
                err_d   = 1'b0;
            end
        endcase

        s_ready_d = (state_d == ST_FILL);
        m_valid_d = (state_d == ST_OUT);
    end

    // State, counters, error flag and handshake outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_FILL;
            cnt_q   <= '0;
            scnt_q  <= '0;
            err_q   <= 1'b0;
            s_ready <= 1'b1;
            m_valid <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            scnt_q  <= scnt_d;
            err_q   <= err_d;
            s_ready <= s_ready_d;
            m_valid <= m_valid_d;
        end
    end

    // Result capture at the end of the settle window
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_data <= '0;
            m_err  <= 1'b0;
        end else if (sample_c) begin
            m_data <= z;
            m_err  <= err_d;
        end
    end

    // Activation vector: written in index order, cleared after each drained result
    always_ff @(posedge clk) begin
        if (!rst_n || clear_c) begin
            for (int i = 0; i < int'(IN); i++) begin
                x[i] <= '0;
            end
        end else if (beat_c) begin
            x[cnt_q] <= s_data;
        end
    end

endmodule

// File: tb/tb_fc_act_loader.sv
// Directed bench for fc_act_loader with a behavioural FC layer driving z.
module tb_fc_act_loader;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned IN     = 128;
    localparam int unsigned SETTLE = 2;
    localparam int unsigned ZW     = WIDTH * 2 + $clog2(IN);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             s_last;
    logic [WIDTH-1:0] x [0:IN-1];
    logic [ZW-1:0]    z;
    logic             m_valid;
    logic             m_ready;
    logic [ZW-1:0]    m_data;
    logic             m_err;

    logic [WIDTH-1:0] stim [0:IN-1];
    int               errors = 0;
    int               checks = 0;
    int               acc;

    always #5 clk = ~clk;

    fc_act_loader #(
        .WIDTH (WIDTH),
        .IN    (IN),
        .SETTLE(SETTLE),
        .ZW    (ZW)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data (s_data),
        .s_last (s_last),
        .x      (x),
        .z      (z),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data (m_data),
        .m_err  (m_err)
    );

    // Constant weights repeating 2, 1, 0, -1
    function automatic int wt(input int i);
        case (i % 4)
            0:       return 2;
            1:       return 1;
            2:       return 0;
            default: return -1;
        endcase
    endfunction

    // Layer model: signed dot product followed by ReLU
    always_comb begin
        acc = 0;
        for (int i = 0; i < int'(IN); i++) begin
            acc = acc + wt(i) * int'($signed(x[i]));
        end
        z = (acc < 0) ? '0 : ZW'(acc);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int xdiff();
        int n = 0;
        for (int i = 0; i < int'(IN); i++) begin
            if (x[i] !== stim[i]) n++;
        end
        return n;
    endfunction

    function automatic int xnonzero();
        int n = 0;
        for (int i = 0; i < int'(IN); i++) begin
            if (x[i] !== '0) n++;
        end
        return n;
    endfunction

    task automatic clear_stim();
        for (int i = 0; i < int'(IN); i++) stim[i] = '0;
    endtask

    // Stream n beats; ramp gives s_data=i, else constant val; last_at<0 never sets s_last
    task automatic send_frame(input int n, input int last_at, input logic [7:0] val,
                              input bit ramp, input bit bub);
        for (int i = 0; i < n; i++) begin
            if (bub) begin
                for (int b = 0; b < 3 && $urandom_range(1, 0) == 0; b++) begin
                    s_valid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            s_valid = 1'b1;
            s_data  = ramp ? 8'(i) : val;
            s_last  = (i == last_at);
            stim[i] = s_data;
            chk("s_ready_fill", 32'(s_ready), 32'd1);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Called one step after the closing beat's edge
    task automatic wait_result(input logic [ZW-1:0] ed, input logic ee);
        chk("s_ready_drop", 32'(s_ready), 32'd0);
        chk("xvec_settle", 32'(xdiff()), 32'd0);
        for (int k = 0; k < int'(SETTLE); k++) begin
            chk("m_valid_early", 32'(m_valid), 32'd0);
            @(posedge clk); #1;
        end
        chk("m_valid_rise", 32'(m_valid), 32'd1);
        chk("m_data", 32'(m_data), 32'(ed));
        chk("m_err", 32'(m_err), 32'(ee));
        chk("xvec_out", 32'(xdiff()), 32'd0);
    endtask

    task automatic handshake();
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        chk("m_valid_drop", 32'(m_valid), 32'd0);
        chk("s_ready_back", 32'(s_ready), 32'd1);
        chk("x_cleared", 32'(xnonzero()), 32'd0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        chk("rst_x", 32'(xnonzero()), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_m_err", 32'(m_err), 32'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        m_ready = 1'b0;
        clear_stim();
        @(posedge clk); #1;
        pulse_reset();

        // Full frame: sum over i of wt(i)*i = 3904
        clear_stim();
        send_frame(128, 127, 8'h00, 1'b1, 1'b0);
        chk("x5_settle", 32'(x[5]), 32'd5);
        wait_result(23'd3904, 1'b0);
        handshake();

        // Backpressure with beats offered while the result is held
        clear_stim();
        send_frame(128, 127, 8'h00, 1'b1, 1'b0);
        wait_result(23'd3904, 1'b0);
        s_valid = 1'b1;
        s_data  = 8'hAA;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            chk("bp_m_valid", 32'(m_valid), 32'd1);
            chk("bp_m_data", 32'(m_data), 32'd3904);
            chk("bp_s_ready", 32'(s_ready), 32'd0);
        end
        handshake();
        s_valid = 1'b0;

        // Early last on beat 9: (2+1+0-1+2+1+0-1+2+1)*127 = 889
        clear_stim();
        send_frame(10, 9, 8'h7F, 1'b0, 1'b0);
        wait_result(23'd889, 1'b1);
        handshake();

        // Missing last: frame still closes at beat 127
        clear_stim();
        send_frame(128, -1, 8'h00, 1'b1, 1'b0);
        wait_result(23'd3904, 1'b1);
        handshake();

        // Next frame starts at x[0]: 3 beats of 5, (2+1+0)*5 = 15
        clear_stim();
        send_frame(3, 2, 8'h05, 1'b0, 1'b0);
        chk("next_x0", 32'(x[0]), 32'd5);
        wait_result(23'd15, 1'b1);
        handshake();

        // Bubbles on s_valid
        clear_stim();
        send_frame(128, 127, 8'h00, 1'b1, 1'b1);
        wait_result(23'd3904, 1'b0);
        handshake();

        // Reset after beat 60, then a clean frame
        clear_stim();
        send_frame(61, -1, 8'h00, 1'b1, 1'b0);
        pulse_reset();
        clear_stim();
        send_frame(128, 127, 8'h00, 1'b1, 1'b0);
        wait_result(23'd3904, 1'b0);
        handshake();

        // Reset while an errored result is held, then a clean frame
        clear_stim();
        send_frame(128, -1, 8'h00, 1'b1, 1'b0);
        wait_result(23'd3904, 1'b1);
        pulse_reset();
        clear_stim();
        send_frame(128, 127, 8'h00, 1'b1, 1'b0);
        wait_result(23'd3904, 1'b0);
        handshake();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fc_act_loader.md
# fc_act_loader

Sequential front/back-end for one fully-connected neuron layer block. It collects a serial stream of WIDTH-bit activations into the IN-entry parallel vector `x[0:IN-1]` that drives the combinational constant-multiplier/adder-tree/ReLU layer. It holds that vector stable for a fixed settle window, then samples the layer's `z` result and offers it downstream on a valid/ready handshake. It replaces a deep combinational path with a multicycle path bounded by SETTLE.

## Interface
- WIDTH, 8, activation width in bits
- IN, 128, activations per frame; must be ≥2
- SETTLE, 2, cycles the vector is held before `z` is sampled; must be ≥1
- ZW, WIDTH*2+$clog2(IN), layer result width (23 at defaults)
- clk  in  1  clock
- rst_n  in  1  reset; one clock; synchronous and active-low
- s_valid  in  1  input beat valid
- s_ready  out  1  loader accepts a beat
- s_data  in  WIDTH  activation, signed two's complement
- s_last  in  1  marks the final beat of a frame
- x  out  WIDTH × [0:IN-1]  registered activation vector to the layer
- z  in  ZW  combinational layer result
- m_valid  out  1  result valid
- m_ready  in  1  downstream accepts the result
- m_data  out  ZW  sampled `z`
- m_err  out  1  frame framing error; qualified by m_valid

## Operation
- States: FILL, SETTLE, OUT.
- Reset (rst_n=0 at a clk edge) forces the following, with any in-flight frame or result discarded:
  - state=FILL, beat counter=0, settle counter=0
  - all x entries=0
  - m_valid=0, m_data=0, m_err=0
- FILL:
  - s_ready=1.
  - Each accepted beat (s_valid&&s_ready) writes s_data into x[cnt], then cnt++.
  - Beats arrive in index order 0..IN-1; there is no other addressing.
- Frame end is the first of:
  - the IN-th accepted beat (cnt==IN-1), or
  - an accepted beat with s_last=1.
- Framing errors. The frame error flag is set on either of:
  - s_last=1 on a beat with cnt<IN-1 (early last); x entries not yet written stay 0.
  - s_last=0 on the beat with cnt==IN-1 (missing last).
- Frame end moves the state to SETTLE and resets cnt to 0.
- SETTLE:
  - s_ready=0 and x is frozen.
  - The state lasts exactly SETTLE cycles.
  - On the last of those cycles, z is registered into m_data and the error flag into m_err, and the state moves to OUT.
- OUT:
  - m_valid=1; m_data and m_err are held until m_valid&&m_ready.
  - On handshake, the next cycle has: state=FILL, m_valid=0, all x entries cleared to 0, error flag cleared.
  - m_data keeps its last value; it is don't-care while m_valid=0.
- m_data is a bit copy of z; no sign extension, rounding or saturation (z is already ReLU'd, non-negative).
- s_ready is registered and depends only on state; it is never combinational on m_ready. There is no accept-while-draining.

## Timing
- Last beat accepted at edge t:
  - s_ready=0 from t+1.
  - z is sampled at edge t+SETTLE.
  - m_valid=1 from t+SETTLE.
- Load-to-result latency is SETTLE cycles after the final beat.
- m_valid&&m_ready at edge u:
  - m_valid=0 and s_ready=1 from u.
  - x reads 0 from u.
- Minimum frame period is IN + SETTLE + 1 cycles with continuous valid/ready.
- s_valid is ignored whenever s_ready=0; beats presented then are not consumed.
- m_ready is ignored when m_valid=0.
- The layer's combinational delay from x to z must meet SETTLE×clk period; the synthesis constraint is a multicycle path of SETTLE.

## Test plan
- **Full frame.** Defaults; stream 128 beats with s_data=i[7:0] and s_last on beat 127; model z with a reference dot product.
  - m_valid rises exactly 2 cycles after beat 127.
  - m_data equals the model; m_err=0; x[5]=5 while in SETTLE.
- **Backpressure.** Same frame, then hold m_ready=0 for 10 cycles.
  - m_valid and m_data stay stable; s_ready=0 throughout.
  - After the handshake, s_ready=1 next cycle and every x entry=0.
- **Early last.** s_last on beat 9 (10 beats of value 0x7F).
  - x[0..9]=0x7F and x[10..127]=0.
  - m_err=1 with m_valid.
- **Missing last.** 128 beats with s_last=0.
  - The frame closes at beat 127 anyway; m_err=1.
  - The next frame starts at x[0].
- **Bubbles.** Randomly toggle s_valid (50%) over a full frame.
  - Result and m_err are identical to the full-frame test.
- **Reset mid-operation.** Assert rst_n=0 for one cycle after beat 60, and separately during OUT.
  - Next cycle: m_valid=0, s_ready=1, all x=0, m_data=0.
  - A following clean frame produces the correct result.
